single_argument_port: RTL and testbench

DUT-side initiator for a scalar (single-word) top-level argument of a dataflow circuit. On `start` it reads the argument word over the single-port memory interface (`ce0`/`we0`/`mem_din0`/`mem_dout0`) and emits it as a valid/ready token. It then accepts a result token, writes it back to the same location and pulses `done`. It sits between the top-level argument port and the first/last dataflow units that consume and produce the argument.

---
 rtl/single_argument_pkg.sv | 21 ++
 rtl/single_argument_port.sv | 177 +++++++++++++++++
 tb/tb_single_argument_port.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/single_argument_pkg.sv
// Shared types and constants for the single-argument port initiator.
// The state enum is 3 bits wide. The latency counter width covers
// READ_LATENCY values 1..7. MIN_TXN_LEN is the start-to-done length in
// cycles (both ends counted) with READ_LATENCY=1, write-back enabled and
// both partners always ready.
package single_argument_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_EMIT    = 3'd3,
        ST_WAIT_IN = 3'd4,
        ST_WR      = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam int unsigned LAT_CNT_W   = 3;
    localparam int unsigned MIN_TXN_LEN = 7;

endpackage

// File: rtl/single_argument_port.sv
// single_argument_port: initiator for a scalar top-level argument.
// On start it reads the argument word through a single-port memory and
// offers it as a valid/ready token. With SINGLE_ARGUMENT_WRITEBACK_EN
// defined, it then accepts a result token, writes it back to the same
// location and pulses done. With the macro undefined, the write-back
// path is not built and done follows the token handshake directly.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a transaction (sampled in IDLE only)
//   ce0, we0, mem_din0  memory request, write enable, write data
//   mem_dout0           memory read data, READ_LATENCY after the read cycle
//   out_data/valid/ready  argument token towards the circuit
//   in_data/valid/ready   result token from the circuit
//   done                one-cycle end-of-transaction pulse
//   txn_count           completed transactions, wraps
module single_argument_port
    import single_argument_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TXN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ce0,
    output logic                  we0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic [TXN_WIDTH-1:0]  txn_count
);

    state_e                state_q, state_d;
    logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [TXN_WIDTH-1:0]  txn_count_q, txn_count_d;
    logic                  ce0_q, ce0_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  we0_q, we0_d;
    logic                  in_ready_q, in_ready_d;
`else
    logic                  unused_in;
`endif

    // Next-state, datapath captures and Moore outputs.
    // Outputs are decoded from the next state so they appear registered
    // in the same cycle as the state they belong to.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        out_data_d  = out_data_q;
        txn_count_d = txn_count_q;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
        mem_din_d   = mem_din_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                lat_cnt_d = LAT_CNT_W'(READ_LATENCY);
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Count value 1 marks the cycle in which mem_dout0 is valid.
                if (lat_cnt_q == LAT_CNT_W'(1)) begin
                    out_data_d = mem_dout0;
                    state_d    = ST_EMIT;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
                    state_d = ST_WAIT_IN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
            ST_WAIT_IN: begin
                if (in_valid) begin
                    mem_din_d = in_data;
                    state_d   = ST_WR;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // DONE always lasts one cycle, so entering it counts exactly once.
        if (state_d == ST_DONE) begin
            txn_count_d = txn_count_q + TXN_WIDTH'(1);
        end

        ce0_d       = (state_d == ST_RD_REQ) || (state_d == ST_WR);
        out_valid_d = (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
        we0_d       = (state_d == ST_WR);
        in_ready_d  = (state_d == ST_WAIT_IN);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            out_data_q  <= '0;
            txn_count_q <= '0;
            ce0_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
            mem_din_q   <= '0;
            we0_q       <= 1'b0;
            in_ready_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            out_data_q  <= out_data_d;
            txn_count_q <= txn_count_d;
            ce0_q       <= ce0_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
            mem_din_q   <= mem_din_d;
            we0_q       <= we0_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign ce0       = ce0_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign txn_count = txn_count_q;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
    assign we0       = we0_q;
    assign mem_din0  = mem_din_q;
    assign in_ready  = in_ready_q;
`else
    // Result token is not consumed without write-back.
    assign we0       = 1'b0;
    assign mem_din0  = '0;
    assign in_ready  = 1'b0;
    assign unused_in = ^{in_data, in_valid};
`endif

endmodule

// File: tb/tb_single_argument_port.sv
// Bench for single_argument_port. Two instances share the stimulus:
// A (READ_LATENCY=1, TXN_WIDTH=16) and B (READ_LATENCY=3, TXN_WIDTH=2).
// A transaction-level reference model predicts every output each cycle.
module tb_single_argument_port;
    import single_argument_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned RL_A = 1;
    localparam int unsigned RL_B = 3;
    localparam int unsigned TW_A = 16;
    localparam int unsigned TW_B = 2;
    localparam logic [DW-1:0] NO_DATA = 32'hBAD0_BAD0;
`ifdef SINGLE_ARGUMENT_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          clk;
    logic          rst, start, out_ready, in_valid;
    logic [DW-1:0] in_data, mem_word;
    logic [DW-1:0] mem_dout0 [2];
    logic [DW-1:0] mem_din0 [2];
    logic [DW-1:0] out_data [2];
    logic          ce0 [2], we0 [2], out_valid [2], in_ready [2], done [2];
    logic [TW_A-1:0] txn_a;
    logic [TW_B-1:0] txn_b;

    single_argument_port #(.DATA_WIDTH(DW), .READ_LATENCY(RL_A), .TXN_WIDTH(TW_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start),
        .ce0(ce0[0]), .we0(we0[0]), .mem_din0(mem_din0[0]), .mem_dout0(mem_dout0[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
        .done(done[0]), .txn_count(txn_a)
    );

    single_argument_port #(.DATA_WIDTH(DW), .READ_LATENCY(RL_B), .TXN_WIDTH(TW_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start),
        .ce0(ce0[1]), .we0(we0[1]), .mem_din0(mem_din0[1]), .mem_dout0(mem_dout0[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
        .done(done[1]), .txn_count(txn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: a read sampled at an edge returns the word READ_LATENCY cycles
    // later; outside that window the bus carries a marker value.
    logic [DW-1:0] pipe_d [2][8];
    logic          pipe_v [2][8];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 7; i > 0; i--) begin
                pipe_d[d][i] <= pipe_d[d][i-1];
                pipe_v[d][i] <= rst ? 1'b0 : pipe_v[d][i-1];
            end
            pipe_d[d][0] <= mem_word;
            pipe_v[d][0] <= rst ? 1'b0 : (ce0[d] && !we0[d]);
        end
    end
    assign mem_dout0[0] = pipe_v[0][RL_A-1] ? pipe_d[0][RL_A-1] : NO_DATA;
    assign mem_dout0[1] = pipe_v[1][RL_B-1] ? pipe_d[1][RL_B-1] : NO_DATA;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start, t_done_a, t_ov_b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: what each cycle of a transaction is doing.
    bit            m_req [2];      // read request cycle
    int            m_rd_left [2];  // cycles left until the read word is captured
    bit            m_offer [2];    // argument token offered
    bit            m_collect [2];  // waiting for the result token
    bit            m_write [2];    // write-back cycle
    bit            m_fin [2];      // done cycle
    logic [DW-1:0] m_rd_word [2], m_out_data [2], m_din [2];
    int            m_txn [2];

    function automatic int rl_of(input int d);
        return (d == 0) ? int'(RL_A) : int'(RL_B);
    endfunction

    function automatic int tw_of(input int d);
        return (d == 0) ? int'(TW_A) : int'(TW_B);
    endfunction

    // Advance the model over one clock edge using the inputs held at that edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_req[d] = 0; m_rd_left[d] = 0; m_offer[d] = 0;
                m_collect[d] = 0; m_write[d] = 0; m_fin[d] = 0;
                m_out_data[d] = '0; m_din[d] = '0; m_txn[d] = 0;
            end else if (m_req[d]) begin
                m_req[d]     = 0;
                m_rd_word[d] = mem_word;
                m_rd_left[d] = rl_of(d);
            end else if (m_rd_left[d] > 0) begin
                if (m_rd_left[d] == 1) begin
                    m_out_data[d] = m_rd_word[d];
                    m_offer[d]    = 1;
                end
                m_rd_left[d]--;
            end else if (m_offer[d]) begin
                if (out_ready) begin
                    m_offer[d] = 0;
                    if (WB) m_collect[d] = 1;
                    else begin
                        m_fin[d] = 1;
                        m_txn[d] = (m_txn[d] + 1) % (1 << tw_of(d));
                    end
                end
            end else if (m_collect[d]) begin
                if (in_valid) begin
                    m_din[d]     = in_data;
                    m_collect[d] = 0;
                    m_write[d]   = 1;
                end
            end else if (m_write[d]) begin
                m_write[d] = 0;
                m_fin[d]   = 1;
                m_txn[d]   = (m_txn[d] + 1) % (1 << tw_of(d));
            end else if (m_fin[d]) begin
                m_fin[d] = 0;
            end else if (start) begin
                m_req[d] = 1;
            end
        end
    endtask

    // One clock: let the DUTs update, then compare every output mid-cycle.
    task automatic step();
        logic [63:0] txn_got;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_step();
        for (int d = 0; d < 2; d++) begin
            txn_got = (d == 0) ? 64'(txn_a) : 64'(txn_b);
            check_eq($sformatf("ce0[%0d]", d),       64'(ce0[d]),       64'(m_req[d] | m_write[d]));
            check_eq($sformatf("we0[%0d]", d),       64'(we0[d]),       64'(m_write[d]));
            check_eq($sformatf("out_valid[%0d]", d), 64'(out_valid[d]), 64'(m_offer[d]));
            check_eq($sformatf("in_ready[%0d]", d),  64'(in_ready[d]),  64'(m_collect[d]));
            check_eq($sformatf("done[%0d]", d),      64'(done[d]),      64'(m_fin[d]));
            check_eq($sformatf("out_data[%0d]", d),  64'(out_data[d]),  64'(m_out_data[d]));
            check_eq($sformatf("mem_din0[%0d]", d),  64'(mem_din0[d]),  64'(m_din[d]));
            check_eq($sformatf("txn_count[%0d]", d), txn_got,           64'(m_txn[d]));
        end
        if (done[0] === 1'b1 && t_done_a < 0) t_done_a = cyc;
        if (out_valid[1] === 1'b1 && t_ov_b < 0) t_ov_b = cyc;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        in_data = '0; mem_word = '0;
        t_start = 0; t_done_a = -1; t_ov_b = -1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single transaction, partners always ready; measure lengths.
        mem_word = 32'h0000_00A5; in_data = 32'h0000_00A6;
        in_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; t_start = cyc; t_done_a = -1; t_ov_b = -1;
        step();
        start = 1'b0;
        repeat (14) step();
        check_eq("txn_len_a", 64'(t_done_a - t_start + 1),
                 64'(WB ? MIN_TXN_LEN : MIN_TXN_LEN - 2));
        check_eq("rd_lat_b", 64'(t_ov_b - t_start), 64'(RL_B + 2));

        // Second word, longer latency instance carries the same token.
        mem_word = 32'hDEAD_BEEF; in_data = 32'h1234_5678;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();

        // Consumer stalls; result-side pulses and start must be ignored.
        out_ready = 1'b0; mem_word = 32'h0BAD_CAFE; in_data = 32'h0000_0055;
        start = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            start    = i[1];
            step();
        end
        start = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) step();
        in_valid = 1'b1;
        repeat (10) step();

        // Reset while waiting for the result token.
        in_valid = 1'b0; mem_word = 32'h0000_7777;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b1;
        repeat (6) step();

        // start held high: back-to-back transactions, counter wrap on B.
        start = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            mem_word = $urandom;
            in_data  = $urandom;
            step();
        end
        start = 1'b0;
        repeat (12) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 1) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            mem_word  = $urandom;
            step();
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
